fetch_queue: RTL

Instruction fetch queue between the instruction cache and `register_decode`. It buffers cache hits as `{pc, instr}` pairs, so a decoder stall does not discard a completed fetch. It tracks the architecturally expected fetch PC and silently drops any stale response whose PC does not match, such as responses still in flight across a jump or flush. On flush it empties in one cycle and re-targets the expected PC.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared core types for the fetch path: the queued {pc, instr} entry and the PC stride.
// Types only; no logic, latency or flow control lives here.
// register_decode reuses fq_entry_t to consume queue entries.
package fetch_queue_pkg;

    localparam int FQ_WORDSZ  = 64;
    localparam int FQ_INSTSZ  = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [FQ_WORDSZ-1:0] pc;
        logic [FQ_INSTSZ-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between icache and decode; drops responses whose PC is stale.
// Latency: an entry pushed at edge N appears on out_* in cycle N+1; no in->out bypass.
// Backpressure: in_ready = !full from registers only; a same-cycle pop never frees a slot.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int INSTSZ = 32,
    parameter int WORDSZ = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORDSZ-1:0]          entry,
    input  logic                       in_valid,
    input  logic [WORDSZ-1:0]          in_pc,
    input  logic [INSTSZ-1:0]          in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WORDSZ-1:0]          out_pc,
    output logic [INSTSZ-1:0]          out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic [WORDSZ-1:0]          flush_pc,
    output logic [WORDSZ-1:0]          expected_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0]   FULL_CNT  = CNTW'(DEPTH);
    localparam logic [WORDSZ-1:0] PC_STRIDE = WORDSZ'(INST_BYTES);
    localparam logic [WORDSZ-1:0] ALIGN_MSK = ~WORDSZ'(3);

    logic [WORDSZ-1:0] pc_mem    [DEPTH];
    logic [INSTSZ-1:0] instr_mem [DEPTH];

    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;
    logic [CNTW-1:0]   cnt_q;
    logic [WORDSZ-1:0] exp_pc_q;
    logic [7:0]        drop_q;

    logic push_fire;
    logic pc_match;
    logic push;
    logic drop;
    logic pop;

    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);

    assign push_fire = in_valid && in_ready && !flush;
    assign pc_match  = (in_pc == exp_pc_q);
    assign push      = push_fire && pc_match;
    assign drop      = push_fire && !pc_match;
    assign pop       = out_valid && out_ready && !flush;

    assign out_pc      = pc_mem[rd_ptr];
    assign out_instr   = instr_mem[rd_ptr];
    assign expected_pc = exp_pc_q;
    assign count       = cnt_q;
    assign drop_count  = drop_q;

    // Storage carries no reset: entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
            exp_pc_q <= entry;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            exp_pc_q <= flush_pc & ALIGN_MSK;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                exp_pc_q <= exp_pc_q + PC_STRIDE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
